// File: rtl/mc_pkg.sv
// Shared types and constants for the multicast bus sequencer.
package mc_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StProgram = 2'd1,
    StRun     = 2'd2
  } state_e;

  localparam int unsigned DROP_CNT_W = 8;

endpackage

// File: rtl/tag_match_mask.sv
// Combinational compare of one tag against every PE's programmed ID.
module tag_match_mask #(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned NUM_PE        = 8
) (
  input  logic [NUM_PE*ADDRESS_WIDTH-1:0] ids,
  input  logic [ADDRESS_WIDTH-1:0]        tag,
  output logic [NUM_PE-1:0]               mask
);

  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      mask[i] = (ids[i*ADDRESS_WIDTH +: ADDRESS_WIDTH] == tag);
    end
  end

endmodule

// File: rtl/multicast_bus_sequencer.sv
// Programs per-PE tag IDs, then issues held (tag, value) packets once every matching PE is ready.
module multicast_bus_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 4,
  parameter int unsigned BITWIDTH      = 16,
  parameter int unsigned NUM_PE        = 8
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            start,
  input  logic                            stop,
  input  logic [NUM_PE*ADDRESS_WIDTH-1:0] id_table,
  output logic [NUM_PE-1:0]               program_sel,
  output logic [ADDRESS_WIDTH-1:0]        prog_tag_id,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ADDRESS_WIDTH-1:0]        in_tag,
  input  logic [BITWIDTH-1:0]             in_value,
  input  logic [NUM_PE-1:0]               pe_ready,
  output logic                            bus_enable,
  output logic [ADDRESS_WIDTH-1:0]        bus_tag,
  output logic [BITWIDTH-1:0]             bus_value,
  output logic                            busy,
  output logic [DROP_CNT_W-1:0]           drop_count
);

  localparam int unsigned IdxW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  state_e                          state_q, state_d;
  logic [IdxW-1:0]                 idx_q, idx_d;
  logic [NUM_PE*ADDRESS_WIDTH-1:0] ids_q, ids_d;
  logic                            stop_pend_q, stop_pend_d;
  logic                            hold_valid_q, hold_valid_d;
  logic [ADDRESS_WIDTH-1:0]        hold_tag_q, hold_tag_d;
  logic [BITWIDTH-1:0]             hold_value_q, hold_value_d;
  logic [NUM_PE-1:0]               hold_mask_q, hold_mask_d;
  logic [NUM_PE-1:0]               program_sel_d;
  logic [ADDRESS_WIDTH-1:0]        prog_tag_id_d;
  logic                            bus_enable_d;
  logic [ADDRESS_WIDTH-1:0]        bus_tag_d;
  logic [BITWIDTH-1:0]             bus_value_d;
  logic [DROP_CNT_W-1:0]           drop_count_d;

  logic [NUM_PE-1:0] in_mask;
  logic              issue, drop, accept, last_idx;

  tag_match_mask #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .NUM_PE       (NUM_PE)
  ) u_tag_match_mask (
    .ids (ids_q),
    .tag (in_tag),
    .mask(in_mask)
  );

  assign issue    = hold_valid_q & (|hold_mask_q) & ~(|(hold_mask_q & ~pe_ready));
  assign drop     = hold_valid_q & ~(|hold_mask_q);
  assign in_ready = (state_q == StRun) & (~hold_valid_q | issue | drop);
  assign accept   = in_valid & in_ready;
  assign busy     = (state_q != StIdle);
  assign last_idx = (idx_q == IdxW'(NUM_PE - 1));

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ids_d         = ids_q;
    stop_pend_d   = 1'b0;
    program_sel_d = '0;
    prog_tag_id_d = '0;
    hold_valid_d  = hold_valid_q;
    hold_tag_d    = hold_tag_q;
    hold_value_d  = hold_value_q;
    hold_mask_d   = hold_mask_q;
    bus_enable_d  = issue;
    bus_tag_d     = bus_tag;
    bus_value_d   = bus_value;
    drop_count_d  = drop_count;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d       = StProgram;
          idx_d         = '0;
          program_sel_d = NUM_PE'(1);
          prog_tag_id_d = id_table[0 +: ADDRESS_WIDTH];
        end
      end
      StProgram: begin
        ids_d[int'(idx_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH] =
            id_table[int'(idx_q)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        if (last_idx) begin
          state_d = StRun;
        end else begin
          idx_d         = idx_q + IdxW'(1);
          program_sel_d = NUM_PE'(1) << idx_d;
          prog_tag_id_d = id_table[int'(idx_d)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        end
      end
      StRun: begin
        // Stop waits for a cycle with nothing held and nothing being taken in.
        stop_pend_d = stop | stop_pend_q;
        if (stop_pend_d && !hold_valid_q && !accept) begin
          state_d     = StIdle;
          stop_pend_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      hold_valid_d = 1'b1;
      hold_tag_d   = in_tag;
      hold_value_d = in_value;
      hold_mask_d  = in_mask;
    end else if (issue || drop) begin
      hold_valid_d = 1'b0;
    end

    if (issue) begin
      bus_tag_d   = hold_tag_q;
      bus_value_d = hold_value_q;
    end

    if (drop && (drop_count != '1)) begin
      drop_count_d = drop_count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      ids_q        <= '0;
      stop_pend_q  <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_tag_q   <= '0;
      hold_value_q <= '0;
      hold_mask_q  <= '0;
      program_sel  <= '0;
      prog_tag_id  <= '0;
      bus_enable   <= 1'b0;
      bus_tag      <= '0;
      bus_value    <= '0;
      drop_count   <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ids_q        <= ids_d;
      stop_pend_q  <= stop_pend_d;
      hold_valid_q <= hold_valid_d;
      hold_tag_q   <= hold_tag_d;
      hold_value_q <= hold_value_d;
      hold_mask_q  <= hold_mask_d;
      program_sel  <= program_sel_d;
      prog_tag_id  <= prog_tag_id_d;
      bus_enable   <= bus_enable_d;
      bus_tag      <= bus_tag_d;
      bus_value    <= bus_value_d;
      drop_count   <= drop_count_d;
    end
  end

endmodule

// File: tb/tb_multicast_bus_sequencer.sv
// Directed and randomized bench for multicast_bus_sequencer against a packet-level model.
module tb_multicast_bus_sequencer;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [31:0] id_table;
  logic [7:0]  program_sel;
  logic [3:0]  prog_tag_id;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_tag = '0;
  logic [15:0] in_value = '0;
  logic [7:0]  pe_ready = 8'hFF;
  logic        bus_enable;
  logic [3:0]  bus_tag;
  logic [15:0] bus_value;
  logic        busy;
  logic [7:0]  drop_count;

  logic [3:0] id_tb [8];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 8; i++) id_table[i*4 +: 4] = id_tb[i];
  end

  multicast_bus_sequencer #(
    .ADDRESS_WIDTH(4),
    .BITWIDTH     (16),
    .NUM_PE       (8)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .start      (start),
    .stop       (stop),
    .id_table   (id_table),
    .program_sel(program_sel),
    .prog_tag_id(prog_tag_id),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_tag     (in_tag),
    .in_value   (in_value),
    .pe_ready   (pe_ready),
    .bus_enable (bus_enable),
    .bus_tag    (bus_tag),
    .bus_value  (bus_value),
    .busy       (busy),
    .drop_count (drop_count)
  );

  // Reference model: mode 0 idle, 1 programming PE m_idx, 2 running.
  typedef struct {
    logic [3:0]  tag;
    logic [15:0] val;
    logic [7:0]  mask;
  } pkt_t;

  pkt_t        hold_q[$];
  int          m_mode, m_idx, m_drops;
  logic [3:0]  m_ids [8];
  bit          m_pend, m_bus_en;
  logic [3:0]  m_bus_tag;
  logic [15:0] m_bus_val;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_idx = 0; m_drops = 0; m_pend = 0;
    m_bus_en = 0; m_bus_tag = '0; m_bus_val = '0;
    hold_q.delete();
    for (int i = 0; i < 8; i++) m_ids[i] = '0;
  endtask

  // Called just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    bit         iss, drp, rdy, acc, leave;
    logic [7:0] msk;
    #1;
    iss = 0; drp = 0;
    if (hold_q.size() != 0) begin
      if (hold_q[0].mask == 0) drp = 1;
      else if ((hold_q[0].mask & ~pe_ready) == 0) iss = 1;
    end
    rdy = (m_mode == 2) && (hold_q.size() == 0 || iss || drp);
    chk("in_ready", in_ready, rdy);
    chk("busy", busy, m_mode != 0);
    chk("program_sel", program_sel, (m_mode == 1) ? (8'd1 << m_idx) : 8'd0);
    if (m_mode == 1) chk("prog_tag_id", prog_tag_id, id_tb[m_idx]);
    chk("bus_enable", bus_enable, m_bus_en);
    chk("bus_tag", bus_tag, m_bus_tag);
    chk("bus_value", bus_value, m_bus_val);
    chk("drop_count", drop_count, m_drops);
    acc = in_valid && rdy;
    @(posedge clk);
    m_bus_en = 0;
    case (m_mode)
      0: if (start) begin m_mode = 1; m_idx = 0; end
      1: begin
        m_ids[m_idx] = id_tb[m_idx];
        if (m_idx == 7) m_mode = 2;
        else m_idx++;
      end
      default: begin
        leave  = (stop || m_pend) && hold_q.size() == 0 && !acc;
        m_pend = (stop || m_pend) && !leave;
        if (iss) begin
          m_bus_en = 1; m_bus_tag = hold_q[0].tag; m_bus_val = hold_q[0].val;
        end
        if (drp && m_drops < 255) m_drops++;
        if (iss || drp) void'(hold_q.pop_front());
        if (acc) begin
          msk = '0;
          for (int i = 0; i < 8; i++) if (m_ids[i] == in_tag) msk[i] = 1'b1;
          hold_q.push_back('{tag: in_tag, val: in_value, mask: msk});
        end
        if (leave) m_mode = 0;
      end
    endcase
    @(negedge clk);
  endtask

  // Asserts reset between edges so its asynchronous effect is visible before any clock.
  task automatic apply_reset();
    #2;
    rstb = 1'b0;
    #1;
    chk("rst_program_sel", program_sel, 0);
    chk("rst_prog_tag_id", prog_tag_id, 0);
    chk("rst_bus_enable", bus_enable, 0);
    chk("rst_bus_tag", bus_tag, 0);
    chk("rst_bus_value", bus_value, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    model_reset();
    @(negedge clk);
    rstb = 1'b1; start = 0; stop = 0; in_valid = 0;
  endtask

  task automatic program_ids();
    start = 1; tick(); start = 0;
    repeat (8) tick();
  endtask

  task automatic send(input logic [3:0] tag, input logic [15:0] val);
    in_valid = 1; in_tag = tag; in_value = val; tick(); in_valid = 0;
  endtask

  task automatic go_idle();
    stop = 1; tick(); stop = 0; tick();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) id_tb[i] = 4'(i);
    model_reset();
    apply_reset();

    // 1: program IDs 0..7, one-hot walk
    start = 1; tick(); start = 0;
    for (int i = 0; i < 8; i++) begin
      chk("t1_walk", program_sel, 32'd1 << i);
      chk("t1_busy", busy, 1);
      tick();
    end
    chk("t1_run_sel", program_sel, 0);

    // 2: single packet, all ready
    send(4'd3, 16'd257);
    chk("t2_lat0", bus_enable, 0);
    tick();
    chk("t2_en", bus_enable, 1);
    chk("t2_tag", bus_tag, 3);
    chk("t2_val", bus_value, 257);
    tick();
    chk("t2_pulse", bus_enable, 0);

    // 3: shared ID, blocked PE1
    go_idle();
    id_tb[0] = 2; id_tb[1] = 2; id_tb[2] = 5; id_tb[3] = 3;
    id_tb[4] = 4; id_tb[5] = 6; id_tb[6] = 7; id_tb[7] = 0;
    program_ids();
    pe_ready = 8'hFD;
    send(4'd2, 16'hBEEF);
    repeat (3) begin
      chk("t3_blocked_ready", in_ready, 0);
      tick();
      chk("t3_no_issue", bus_enable, 0);
    end
    pe_ready = 8'hFF;
    tick();
    chk("t3_issue", bus_enable, 1);
    chk("t3_val", bus_value, 16'hBEEF);

    // 4: unmatched tag dropped, next packet follows without a bubble
    in_valid = 1; in_tag = 9; in_value = 16'h1111; tick();
    in_tag = 3; in_value = 16'h2222; tick();
    in_valid = 0;
    chk("t4_drop", drop_count, 1);
    chk("t4_no_bus", bus_enable, 0);
    tick();
    chk("t4_issue", bus_enable, 1);
    chk("t4_tag", bus_tag, 3);

    // 5: four back-to-back packets, then stop while one is held
    tick();
    in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      in_tag = (i % 2 == 0) ? 4'd5 : 4'd4; in_value = 16'(100 + i); tick();
      if (i > 0) chk("t5_burst", bus_enable, 1);
    end
    in_valid = 0;
    tick();
    chk("t5_burst_last", bus_enable, 1);
    pe_ready = 8'hF7;
    send(4'd3, 16'h0033);
    stop = 1; tick(); stop = 0;
    repeat (3) begin
      tick();
      chk("t5_stop_wait", busy, 1);
    end
    pe_ready = 8'hFF;
    tick();
    chk("t5_issue_before_idle", bus_enable, 1);
    tick();
    chk("t5_idle", busy, 0);

    // 6: reset mid-program and mid-run
    start = 1; tick(); start = 0;
    repeat (4) tick();
    chk("t6_idx4", program_sel, 8'h10);
    apply_reset();
    program_ids();
    pe_ready = 8'hF7;
    send(4'd3, 16'h0606);
    tick();
    apply_reset();
    pe_ready = 8'hFF;
    repeat (3) tick();

    // Random traffic with occasional stop/restart and reprogramming while idle
    for (int i = 0; i < 8; i++) id_tb[i] = 4'($urandom_range(0, 15));
    program_ids();
    for (int c = 0; c < 3000; c++) begin
      if (m_mode == 0 && $urandom_range(0, 3) == 0)
        for (int i = 0; i < 8; i++) id_tb[i] = 4'($urandom_range(0, 15));
      start    = ($urandom_range(0, 7) == 0);
      stop     = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_tag   = 4'($urandom_range(0, 15));
      in_value = 16'($urandom);
      pe_ready = ~(8'($urandom) & 8'($urandom) & 8'($urandom));
      tick();
    end
    start = 0; stop = 0; in_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
